mips_control_fsm: RTL and testbench
===================================

Name: mips_control_fsm

Overview:
- Multi-cycle control unit that drives the single-cycle MIPS datapath top (PC, instruction memory, register file, ALU, sign extender).
- Consumes the opcode/funct fields decoded by instruction memory; produces the datapath enables, mux selects and ALU operation code.
- Sequences each instruction through FETCH/DECODE/EXEC/WB; supports start/stop, a halt opcode, illegal-instruction flagging and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, reset, asynchronous, active-low (0 = reset).
- start, input, 1, level; begins execution from IDLE.
- stop, input, 1, level; sampled in WB, returns to IDLE after current instruction.
- op, input, 6, instruction[31:26] from instruction memory.
- funct, input, 6, instruction[5:0] from instruction memory.
- pc_en, output, 1, PC enable (drives datapath en).
- rf_en, output, 1, register-file write enable (drives en_rf).
- selec_mux, output, 1, write-register select: 1 = rd (R-type), 0 = I-type destination field.
- selec_mux2, output, 1, ALU B select: 1 = sign-extended immediate, 0 = rD2.
- alu_op, output, 4, ALU operation.
- busy, output, 1, high in FETCH/DECODE/EXEC/WB.
- halted, output, 1, high in HALTED.
- illegal, output, 1, sticky; set on an undecodable instruction.
- instr_count, output, CNT_W, retired legal instructions.

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0; decoded registers cleared.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED. All outputs are Moore, registered from state plus decoded registers.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH, 1 cycle: instruction memory settles from PC -> DECODE.
- DECODE, 1 cycle: latch op/funct into dec_alu_op, dec_imm, dec_rd and dec_legal.
  - op=HALT -> HALTED.
  - Otherwise -> EXEC.
- EXEC, 1 cycle: drive alu_op, selec_mux and selec_mux2 from the decoded registers -> WB.
- WB, 1 cycle:
  - pc_en=1.
  - rf_en=dec_legal.
  - alu_op and selects held at their EXEC values.
  - instr_count += 1 if dec_legal; wraps modulo 2^CNT_W.
  - Next state: stop=1 -> IDLE, else FETCH.
- Latency: 4 cycles per instruction; pc_en and rf_en are exactly 1-cycle pulses per instruction.
- Outside EXEC/WB: alu_op=0, selects=0. pc_en and rf_en are 0 outside WB.
- HALTED: absorbing until reset; pc_en=rf_en=0; busy=0; halted=1; start ignored.
- Illegal op or R-type funct:
  - illegal set (sticky until reset).
  - No register write; PC still advances (instruction skipped); count not incremented.
- start and stop both high in IDLE: start wins -> FETCH. stop is then honoured at the first WB.
- stop asserted outside WB: no effect.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0, including any pc_en/rf_en pulse in flight.

Decomposition:
- Package mips_ctrl_pkg:
  - Opcodes: OP_RTYPE=6'h00, OP_ADDI=6'h08, OP_SLTI=6'h0A, OP_ANDI=6'h0C, OP_ORI=6'h0D, OP_HALT=6'h3F.
  - Funct codes: F_ADD=6'h20, F_SUB=6'h22, F_AND=6'h24, F_OR=6'h25, F_NOR=6'h27, F_SLT=6'h2A.
  - ALU codes: ALU_AND=4'd0, ALU_OR=4'd1, ALU_ADD=4'd2, ALU_SUB=4'd6, ALU_SLT=4'd7, ALU_NOR=4'd12.
  - State enum.
- Sub-module mips_alu_decode: combinational op/funct -> {alu_op, imm_sel, rd_sel, legal}; instantiated once, output captured in DECODE.
- Decode table:
  - R-type: selec_mux=1, selec_mux2=0, alu_op from funct.
  - I-type: selec_mux=0, selec_mux2=1; ADDI->ADD, SLTI->SLT, ANDI->AND, ORI->OR.

Test Plan:
- Reset then start=1 with op=00, funct=20 -> pc_en pulse at cycle 4 after start; rf_en=1, selec_mux=1, selec_mux2=0, alu_op=2 in EXEC/WB; instr_count=1.
- ADDI (op=08) then ORI (op=0D) with start held -> alu_op 2 then 1, selec_mux2=1, selec_mux=0; two pc_en pulses 4 cycles apart; instr_count=2.
- op=00, funct=3F -> illegal=1 (sticky), rf_en=0 in WB, pc_en=1, instr_count unchanged.
- op=3F after one ADD -> HALTED, halted=1, busy=0; start pulses ignored; PC enable never reasserted; rst returns to IDLE.
- stop=1 asserted during EXEC of a SUB -> WB completes (rf_en=1, alu_op=6), then IDLE with busy=0; stop during FETCH alone has no effect.
- CNT_W=2, five legal instructions -> instr_count 1,2,3,0,1; rst low mid-EXEC -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funct codes,
// ALU operation codes, controller states and the decoded-instruction record.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_NOR = 6'h27;
   localparam logic [5:0] F_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALTED = 3'd5
   } state_e;

   // Result of decoding one instruction; illegal encodings decode to all-zero.
   typedef struct packed {
      logic [3:0] alu_op;
      logic       imm_sel;
      logic       rd_sel;
      logic       legal;
   } dec_t;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational op/funct decoder. HALT and unknown encodings report legal=0
// with every control field cleared; the FSM tells HALT apart by opcode.
module mips_alu_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec = '0;
      case (op)
         OP_RTYPE: begin
            dec.rd_sel = 1'b1;
            dec.legal  = 1'b1;
            case (funct)
               F_ADD:   dec.alu_op = ALU_ADD;
               F_SUB:   dec.alu_op = ALU_SUB;
               F_AND:   dec.alu_op = ALU_AND;
               F_OR:    dec.alu_op = ALU_OR;
               F_NOR:   dec.alu_op = ALU_NOR;
               F_SLT:   dec.alu_op = ALU_SLT;
               default: dec = '0;
            endcase
         end
         OP_ADDI: dec = '{alu_op: ALU_ADD, imm_sel: 1'b1, rd_sel: 1'b0, legal: 1'b1};
         OP_SLTI: dec = '{alu_op: ALU_SLT, imm_sel: 1'b1, rd_sel: 1'b0, legal: 1'b1};
         OP_ANDI: dec = '{alu_op: ALU_AND, imm_sel: 1'b1, rd_sel: 1'b0, legal: 1'b1};
         OP_ORI:  dec = '{alu_op: ALU_OR,  imm_sel: 1'b1, rd_sel: 1'b0, legal: 1'b1};
         default: dec = '0;
      endcase
   end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/WB sequencing with start/stop,
// HALT, sticky illegal flag and a retired-instruction counter.
module mips_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   output logic             pc_en,
   output logic             rf_en,
   output logic             selec_mux,
   output logic             selec_mux2,
   output logic [3:0]       alu_op,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   state_e           state_q, state_d;
   dec_t             dec_q, dec_d, dec_w;
   logic             pc_en_q, pc_en_d;
   logic             rf_en_q, rf_en_d;
   logic             sel_rd_q, sel_rd_d;
   logic             sel_imm_q, sel_imm_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic             busy_q, busy_d;
   logic             halted_q, halted_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             drive_alu;

   mips_alu_decode u_dec (
      .op    (op),
      .funct (funct),
      .dec   (dec_w)
   );

   always_comb begin
      state_d   = state_q;
      dec_d     = dec_q;
      illegal_d = illegal_q;
      count_d   = count_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            dec_d = dec_w;
            if (op == OP_HALT) begin
               state_d = ST_HALTED;
            end else begin
               state_d = ST_EXEC;
               if (!dec_w.legal) illegal_d = 1'b1;
            end
         end
         ST_EXEC:   state_d = ST_WB;
         ST_WB: begin
            if (dec_q.legal) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = stop ? ST_IDLE : ST_FETCH;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase

      // Outputs are a pure function of the upcoming state so they can be registered.
      drive_alu  = (state_d == ST_EXEC) || (state_d == ST_WB);
      busy_d     = (state_d == ST_FETCH) || (state_d == ST_DECODE) || drive_alu;
      halted_d   = (state_d == ST_HALTED);
      pc_en_d    = (state_d == ST_WB);
      rf_en_d    = (state_d == ST_WB) && dec_d.legal;
      alu_op_d   = drive_alu ? dec_d.alu_op  : 4'd0;
      sel_rd_d   = drive_alu ? dec_d.rd_sel  : 1'b0;
      sel_imm_d  = drive_alu ? dec_d.imm_sel : 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         dec_q     <= '0;
         pc_en_q   <= 1'b0;
         rf_en_q   <= 1'b0;
         sel_rd_q  <= 1'b0;
         sel_imm_q <= 1'b0;
         alu_op_q  <= 4'd0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         dec_q     <= dec_d;
         pc_en_q   <= pc_en_d;
         rf_en_q   <= rf_en_d;
         sel_rd_q  <= sel_rd_d;
         sel_imm_q <= sel_imm_d;
         alu_op_q  <= alu_op_d;
         busy_q    <= busy_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

   assign pc_en       = pc_en_q;
   assign rf_en       = rf_en_q;
   assign selec_mux   = sel_rd_q;
   assign selec_mux2  = sel_imm_q;
   assign alu_op      = alu_op_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign illegal     = illegal_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Randomized and directed bench for mips_control_fsm against an instruction-level
// reference model that tracks progress through each 4-cycle instruction.
module tb_mips_control_fsm;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [5:0]       op = 6'h00;
   logic [5:0]       funct = 6'h00;
   logic             pc_en, rf_en, selec_mux, selec_mux2, busy, halted, illegal;
   logic [3:0]       alu_op;
   logic [CNT_W-1:0] instr_count;

   int checks = 0;
   int errors = 0;

   // Reference: pos = -1 when idle, else cycles elapsed in the current instruction (0..3).
   int m_pos = -1;
   bit m_halt = 0;
   bit m_ill = 0;
   int m_cnt = 0;
   int m_alu = 0;
   bit m_imm = 0, m_rd = 0, m_legal = 0;

   always #5 clk = ~clk;

   mips_control_fsm #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .op          (op),
      .funct       (funct),
      .pc_en       (pc_en),
      .rf_en       (rf_en),
      .selec_mux   (selec_mux),
      .selec_mux2  (selec_mux2),
      .alu_op      (alu_op),
      .busy        (busy),
      .halted      (halted),
      .illegal     (illegal),
      .instr_count (instr_count)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic ref_decode(input int o, input int f, output int alu,
                             output bit imm, output bit rd, output bit legal);
      alu = 0; imm = 0; rd = 0; legal = 0;
      if (o == 0) begin
         legal = 1; rd = 1;
         if      (f == 'h20) alu = 2;
         else if (f == 'h22) alu = 6;
         else if (f == 'h24) alu = 0;
         else if (f == 'h25) alu = 1;
         else if (f == 'h27) alu = 12;
         else if (f == 'h2A) alu = 7;
         else begin legal = 0; rd = 0; end
      end else if (o == 'h08) begin legal = 1; imm = 1; alu = 2; end
      else if (o == 'h0A) begin legal = 1; imm = 1; alu = 7; end
      else if (o == 'h0C) begin legal = 1; imm = 1; alu = 0; end
      else if (o == 'h0D) begin legal = 1; imm = 1; alu = 1; end
   endtask

   task automatic model_reset();
      m_pos = -1; m_halt = 0; m_ill = 0; m_cnt = 0;
      m_alu = 0; m_imm = 0; m_rd = 0; m_legal = 0;
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      if (m_halt) return;
      if (m_pos < 0) begin
         if (start) m_pos = 0;
      end else if (m_pos == 0) begin
         m_pos = 1;
      end else if (m_pos == 1) begin
         if (op == 6'h3F) begin
            m_halt = 1; m_pos = -1;
         end else begin
            ref_decode(int'(op), int'(funct), m_alu, m_imm, m_rd, m_legal);
            if (!m_legal) m_ill = 1;
            m_pos = 2;
         end
      end else if (m_pos == 2) begin
         m_pos = 3;
      end else begin
         if (m_legal) m_cnt = (m_cnt + 1) % (1 << CNT_W);
         m_pos = stop ? -1 : 0;
      end
   endtask

   task automatic compare_all();
      bit ex = (m_pos == 2) || (m_pos == 3);
      chk("pc_en",   int'(pc_en),       int'(m_pos == 3));
      chk("rf_en",   int'(rf_en),       int'(m_pos == 3 && m_legal));
      chk("alu_op",  int'(alu_op),      ex ? m_alu : 0);
      chk("sel_rd",  int'(selec_mux),   int'(ex && m_rd));
      chk("sel_imm", int'(selec_mux2),  int'(ex && m_imm));
      chk("busy",    int'(busy),        int'(m_pos >= 0));
      chk("halted",  int'(halted),      int'(m_halt));
      chk("illegal", int'(illegal),     int'(m_ill));
      chk("count",   int'(instr_count), m_cnt);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   // One full instruction from IDLE (start held) or from the previous WB.
   task automatic instr(input logic [5:0] o, input logic [5:0] f);
      op = o; funct = f;
      repeat (4) cyc();
      $display("instr op=%02h funct=%02h alu_op=%0d rf_en=%0b count=%0d illegal=%0b",
               o, f, alu_op, rf_en, instr_count, illegal);
   endtask

   task automatic async_reset();
      #3 rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      $display("async reset busy=%0b pc_en=%0b alu_op=%0d", busy, pc_en, alu_op);
      #1 rst = 1'b1;
   endtask

   initial begin
      logic [5:0] ops[6];
      logic [5:0] fns[8];
      ops = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h00};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F, 6'h01};

      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst = 1'b1;

      // ADD, ADDI, ORI, illegal R-type, then SUB with stop raised in EXEC
      start = 1'b1;
      instr(6'h00, 6'h20);
      instr(6'h08, 6'h00);
      instr(6'h0D, 6'h00);
      instr(6'h00, 6'h3F);
      op = 6'h00; funct = 6'h22;
      repeat (3) cyc();
      stop = 1'b1;
      cyc();
      start = 1'b0;
      repeat (2) cyc();
      stop = 1'b0;

      // stop during FETCH only: must not end the instruction
      start = 1'b1; stop = 1'b1; op = 6'h0A; funct = 6'h00;
      cyc();
      stop = 1'b0;
      repeat (3) cyc();

      // five legal instructions to wrap the 2-bit counter
      for (int i = 0; i < 5; i++) instr(ops[i], 6'h24);

      // ADD then HALT; start pulses must be ignored
      instr(6'h00, 6'h20);
      op = 6'h3F;
      repeat (3) cyc();
      for (int i = 0; i < 6; i++) begin
         start = i[0];
         cyc();
      end
      async_reset();

      // reset while in EXEC
      start = 1'b1; op = 6'h00; funct = 6'h25;
      repeat (3) cyc();
      async_reset();

      // randomized stream
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 9) < 7);
         stop  = ($urandom_range(0, 9) == 0);
         op    = ($urandom_range(0, 39) == 0) ? 6'h3F :
                 ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
         funct = fns[$urandom_range(0, 7)];
         cyc();
         if (halted && $urandom_range(0, 3) == 0) async_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
